// File: rtl/wave_gen_pkg.sv
// Shared types and helpers for the wave_gen_dds waveform generator.
// Mode encodings, midscale and amplitude saturation.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        MODE_TRI    = 2'b00,
        MODE_SAW_UP = 2'b01,
        MODE_SQUARE = 2'b10,
        MODE_SAW_DN = 2'b11
    } mode_e;

    function automatic logic [31:0] midscale(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] amp_sat(
        input logic [31:0] a,
        input int unsigned aw
    );
        logic [31:0] lim;
        lim = 32'd1 << aw;
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/wave_gen_dds_shaper.sv
// Stages 1-3: shape, centre, scale and recentre one sample per cycle.
// With WAVE_SYNC_EN a wrap tag rides alongside each sample.
module wave_shaper
    import wave_gen_pkg::*;
#(
    parameter int PHASE_W = 8,
    parameter int DAC_W   = 14,
    parameter int AMP_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [DAC_W:0]     acc_top_i,
    input  logic [PHASE_W-1:0] phase_i,
    input  mode_e              mode_i,
    input  logic [AMP_W:0]     amp_i,
`ifdef WAVE_SYNC_EN
    input  logic               tag_i,
    output logic               tag_o,
`endif
    output logic [DAC_W-1:0]   dac_o,
    output logic               valid_o
);

    localparam int PROD_W = DAC_W + AMP_W + 2;
    localparam logic [DAC_W:0] MID1 = (DAC_W+1)'(midscale(DAC_W));
    localparam logic signed [PROD_W-1:0] MIDP = PROD_W'(midscale(DAC_W));

    logic [DAC_W:0]             p;
    logic                       m;
    logic [DAC_W-1:0]           u;
    logic [DAC_W-1:0]           s;
    logic [DAC_W-1:0]           raw_d, raw_q;
    logic [AMP_W:0]             amp_d, amp_q;
    logic signed [DAC_W:0]      d;
    logic signed [PROD_W-1:0]   prod_d, prod_q;
    logic signed [PROD_W-1:0]   scaled;
    logic [DAC_W-1:0]           dac_d, dac_q;
    logic                       v1_q, v2_q, v3_q;

    // Phase sits wholly above the bits dropped here, so no carry is lost
    always_comb begin
        p = acc_top_i + ((DAC_W+1)'(phase_i) << (DAC_W + 1 - PHASE_W));
        m = p[DAC_W];
        u = p[DAC_W-1:0];
        s = p[DAC_W:1];
        raw_d = '0;
        unique case (mode_i)
            MODE_TRI:    raw_d = m ? ~u : u;
            MODE_SAW_UP: raw_d = s;
            MODE_SQUARE: raw_d = m ? '0 : '1;
            MODE_SAW_DN: raw_d = ~s;
        endcase
        amp_d  = (AMP_W+1)'(amp_sat(32'(amp_i), AMP_W));
        d      = $signed({1'b0, raw_q} - MID1);
        prod_d = $signed({{(AMP_W+1){d[DAC_W]}}, d})
               * $signed({{(DAC_W+1){1'b0}}, amp_q});
        scaled = prod_q >>> AMP_W;
        dac_d  = v2_q ? DAC_W'(scaled + MIDP) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en_i) begin
            raw_q  <= '0;
            amp_q  <= '0;
            prod_q <= '0;
            dac_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
        end else begin
            raw_q  <= raw_d;
            amp_q  <= amp_d;
            prod_q <= prod_d;
            dac_q  <= dac_d;
            v1_q   <= 1'b1;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
        end
    end

`ifdef WAVE_SYNC_EN
    logic t1_q, t2_q, t3_q;

    always_ff @(posedge clk) begin
        if (!rst_n || !en_i) begin
            t1_q <= 1'b0;
            t2_q <= 1'b0;
            t3_q <= 1'b0;
        end else begin
            t1_q <= tag_i;
            t2_q <= t1_q;
            t3_q <= t2_q;
        end
    end

    assign tag_o = t3_q;
`endif

    assign dac_o   = dac_q;
    assign valid_o = v3_q;

endmodule

// File: rtl/wave_gen_dds.sv
// Arithmetic DDS generator: accumulator, double-buffered config, shaper.
// Optional WAVE_SYNC_EN adds sync_out, one pulse per period wrap.
module wave_gen_dds
    import wave_gen_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int FREQ_W  = 16,
    parameter int PHASE_W = 8,
    parameter int DAC_W   = 14,
    parameter int AMP_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [FREQ_W-1:0]  freq,
    input  logic [AMP_W:0]     amp,
    input  logic [PHASE_W-1:0] phase,
    input  logic [1:0]         mode,
    output logic               cfg_pending,
`ifdef WAVE_SYNC_EN
    output logic               sync_out,
`endif
    output logic [DAC_W-1:0]   dac_out,
    output logic               dac_valid
);

    localparam logic [AMP_W:0] AMP_ONE = {1'b1, {AMP_W{1'b0}}};

    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic               carry;
    logic               apply;
    logic               pend_q, pend_d;

    logic [FREQ_W-1:0]  sh_freq_q, sh_freq_d, act_freq_q, act_freq_d;
    logic [AMP_W:0]     sh_amp_q, sh_amp_d, act_amp_q, act_amp_d;
    logic [PHASE_W-1:0] sh_phase_q, sh_phase_d, act_phase_q, act_phase_d;
    mode_e              sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;

    // Config reaches active only at a wrap, so a period never mixes settings
    always_comb begin
        {carry, acc_sum} = {1'b0, acc_q}
                         + {{(ACC_W+1-FREQ_W){1'b0}}, act_freq_q};
        acc_d = en ? acc_sum : '0;
        apply = pend_q & ~cfg_load & (~en | carry);

        sh_freq_d  = sh_freq_q;
        sh_amp_d   = sh_amp_q;
        sh_phase_d = sh_phase_q;
        sh_mode_d  = sh_mode_q;
        if (cfg_load) begin
            sh_freq_d  = freq;
            sh_amp_d   = amp;
            sh_phase_d = phase;
            sh_mode_d  = mode_e'(mode);
        end

        act_freq_d  = act_freq_q;
        act_amp_d   = act_amp_q;
        act_phase_d = act_phase_q;
        act_mode_d  = act_mode_q;
        if (apply) begin
            act_freq_d  = sh_freq_q;
            act_amp_d   = sh_amp_q;
            act_phase_d = sh_phase_q;
            act_mode_d  = sh_mode_q;
        end

        pend_d = cfg_load | (pend_q & ~apply);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            pend_q      <= 1'b0;
            sh_freq_q   <= '0;
            sh_amp_q    <= AMP_ONE;
            sh_phase_q  <= '0;
            sh_mode_q   <= MODE_TRI;
            act_freq_q  <= '0;
            act_amp_q   <= AMP_ONE;
            act_phase_q <= '0;
            act_mode_q  <= MODE_TRI;
        end else begin
            acc_q       <= acc_d;
            pend_q      <= pend_d;
            sh_freq_q   <= sh_freq_d;
            sh_amp_q    <= sh_amp_d;
            sh_phase_q  <= sh_phase_d;
            sh_mode_q   <= sh_mode_d;
            act_freq_q  <= act_freq_d;
            act_amp_q   <= act_amp_d;
            act_phase_q <= act_phase_d;
            act_mode_q  <= act_mode_d;
        end
    end

`ifdef WAVE_SYNC_EN
    logic wrap_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= en & carry;
        end
    end
`endif

    wave_shaper #(
        .PHASE_W (PHASE_W),
        .DAC_W   (DAC_W),
        .AMP_W   (AMP_W)
    ) u_shaper (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en),
        .acc_top_i (acc_q[ACC_W-1 -: DAC_W+1]),
        .phase_i   (act_phase_q),
        .mode_i    (act_mode_q),
        .amp_i     (act_amp_q),
`ifdef WAVE_SYNC_EN
        .tag_i     (wrap_q),
        .tag_o     (sync_out),
`endif
        .dac_o     (dac_out),
        .valid_o   (dac_valid)
    );

    assign cfg_pending = pend_q;

endmodule
